instr_fetch: RTL and testbench

Instruction fetch stage for the LEGv8 single-cycle/pipelined datapath. It holds the program counter and reads the instruction ROM. It presents `instruction` and its PC to `iDecode`, and accepts the branch-resolution signals that come back from decode/execute. It is the producer end of the instruction interface that `iDecode` consumes. It redirects the PC on taken branches and squashes the wrong-path fetch.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/instr_mem.sv | 20 ++
 rtl/instr_fetch.sv | 108 ++++++++++
 tb/tb_instr_fetch.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// FETCH_HALT_DETECT_EN adds the HALTED state.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

package fetch_pkg;

`ifdef FETCH_HALT_DETECT_EN
  typedef enum logic [1:0] {
    FILL,
    RUN,
    REDIRECT,
    HALTED
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    FILL,
    RUN,
    REDIRECT
  } fetch_state_t;
`endif

  localparam int unsigned PC_INCR  = 4;
  localparam int unsigned BR_SHIFT = 2;

endpackage

// File: rtl/instr_mem.sv
// Synchronous-read instruction ROM.
// Contents are preloaded by the environment.
module instr_mem #(
  parameter int IMEM_DEPTH = 64,
  parameter     IMEM_INIT  = "instructions.mem",
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [AW-1:0]         addr,
  output logic [`INSTR_LEN-1:0] rdata
);

  logic [`INSTR_LEN-1:0] mem [IMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/instr_fetch.sv
// LEGv8 instruction fetch stage: PC, ROM read, branch redirect.
// FETCH_HALT_DETECT_EN stops fetch on an all-zero word.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int               IMEM_DEPTH = 64,
  parameter logic [`WORD-1:0] RESET_PC   = 64'h0,
  parameter                   IMEM_INIT  = "instructions.mem"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch,
  input  logic                  uncondbranch,
  input  logic                  zero,
  input  logic [`WORD-1:0]      sign_extended_output,
  output logic [`INSTR_LEN-1:0] instruction,
  output logic [`WORD-1:0]      pc_out,
  output logic                  instr_valid
);

  localparam int AW = $clog2(IMEM_DEPTH);

  fetch_state_t          state_q, state_d;
  logic [`WORD-1:0]      fetch_pc_q, fetch_pc_d;
  logic [`WORD-1:0]      pc_q, pc_d;
  logic [`INSTR_LEN-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic [`WORD-1:0]      target, rom_pc;
  logic [`INSTR_LEN-1:0] rom_word;
  logic                  take, redirect, do_load;

  assign take = valid_q &
    (uncondbranch | (branch & zero));
  assign target = pc_q +
    (sign_extended_output << BR_SHIFT);

  assign redirect = (state_q == RUN) & take;
  assign do_load  = (state_q == FILL) |
                    (state_q == REDIRECT) |
                    ((state_q == RUN) & ~take);

  // ROM is addressed with the next fetch_pc, so rom_word
  // always holds ROM[fetch_pc_q] when a load happens.
  assign rom_pc = reset ? RESET_PC : fetch_pc_d;

  instr_mem #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .IMEM_INIT  (IMEM_INIT)
  ) u_mem (
    .clk   (clk),
    .en    (reset | ~stall),
    .addr  (rom_pc[AW+1:2]),
    .rdata (rom_word)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    priority case (1'b1)
      stall: ;
      redirect: begin
        fetch_pc_d = target;
        valid_d    = 1'b0;
        state_d    = REDIRECT;
      end
      do_load: begin
        instr_d    = rom_word;
        pc_d       = fetch_pc_q;
        valid_d    = 1'b1;
        fetch_pc_d = fetch_pc_q + `WORD'(PC_INCR);
        state_d    = RUN;
`ifdef FETCH_HALT_DETECT_EN
        if (rom_word == '0) begin
          valid_d    = 1'b0;
          fetch_pc_d = fetch_pc_q;
          state_d    = HALTED;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FILL;
      fetch_pc_q <= RESET_PC;
      pc_q       <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign instruction = instr_q;
  assign pc_out      = pc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus random bench for instr_fetch
// against a cycle-level reference model.
module tb_instr_fetch;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset, stall, branch;
  logic        uncondbranch, zero;
  logic [63:0] sign_extended_output;
  logic [31:0] instruction;
  logic [63:0] pc_out;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [DEPTH];

  logic [63:0] m_fpc, m_pc;
  logic [31:0] m_ins;
  logic        m_v, m_halt;

  instr_fetch #(
    .IMEM_DEPTH (DEPTH),
    .RESET_PC   (64'h0),
    .IMEM_INIT  ("")
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .stall                (stall),
    .branch               (branch),
    .uncondbranch         (uncondbranch),
    .zero                 (zero),
    .sign_extended_output (sign_extended_output),
    .instruction          (instruction),
    .pc_out               (pc_out),
    .instr_valid          (instr_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, s, b, u, z,
                       input logic [63:0] off);
    logic [31:0] w;
    if (r) begin
      m_fpc = 64'h0; m_pc = 0; m_ins = 0;
      m_v = 0; m_halt = 0;
    end else if (s || m_halt) begin
    end else if (m_v && (u || (b && z))) begin
      m_fpc = m_pc + off * 4;
      m_v = 0;
    end else begin
      w = rom[(m_fpc / 4) % DEPTH];
      m_ins = w;
      m_pc  = m_fpc;
`ifdef FETCH_HALT_DETECT_EN
      if (w == 0) begin
        m_v = 0; m_halt = 1;
      end else begin
        m_v = 1; m_fpc = m_fpc + 4;
      end
`else
      m_v = 1; m_fpc = m_fpc + 4;
`endif
    end
  endtask

  task automatic step(input logic r, s, b, u, z,
                      input logic [63:0] off);
    reset = r; stall = s; branch = b;
    uncondbranch = u; zero = z;
    sign_extended_output = off;
    @(posedge clk);
    model(r, s, b, u, z, off);
    #1;
    chk("m_instr", 64'(instruction), 64'(m_ins));
    chk("m_pc", pc_out, m_pc);
    chk("m_valid", 64'(instr_valid), 64'(m_v));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 64'h0);
  endtask

  initial begin
    logic r, s, b, u, z;
    logic [63:0] off;
    reset = 1; stall = 0; branch = 0;
    uncondbranch = 0; zero = 0;
    sign_extended_output = 0;
    for (int i = 0; i < DEPTH; i++)
      rom[i] = $urandom | 32'h1;
    rom[0] = 32'hF84402C9;
    rom[3] = 32'h0;
    for (int i = 0; i < DEPTH; i++)
      dut.u_mem.mem[i] = rom[i];

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_instr", 64'(instruction), 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_valid", 64'(instr_valid), 0);

    idle();
    chk("first_instr", 64'(instruction),
        64'h F84402C9);
    chk("first_valid", 64'(instr_valid), 1);
    idle();
    chk("seq_pc4", pc_out, 64'h4);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, 0, 64'h0);
      chk("stall_pc", pc_out, 64'h4);
      chk("stall_ins", 64'(instruction), 64'(rom[1]));
    end
    idle();
    chk("seq_pc8", pc_out, 64'h8);
    chk("seq_ins2", 64'(instruction), 64'(rom[2]));

    step(0, 0, 1, 0, 1, -64'sd2);
    chk("cbz_bubble", 64'(instr_valid), 0);
    idle();
    chk("cbz_pc", pc_out, 64'h0);
    chk("cbz_ins", 64'(instruction), 64'(rom[0]));
    idle();
    step(0, 0, 0, 1, 0, 64'd16);
    chk("b_bubble", 64'(instr_valid), 0);
    idle();
    chk("b_pc", pc_out, 64'h44);
    chk("b_ins", 64'(instruction), 64'(rom[17]));

    step(1, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, 1, 0, 64'd64);
    idle();
    chk("wrap_pc", pc_out, 64'h100);
    chk("wrap_ins", 64'(instruction), 64'(rom[0]));

    step(0, 1, 0, 1, 0, 64'd64);
    step(0, 1, 0, 1, 0, 64'd64);
    chk("defer_valid", 64'(instr_valid), 1);
    step(0, 0, 0, 1, 0, 64'd64);
    chk("defer_bubble", 64'(instr_valid), 0);
    idle();
    chk("defer_pc", pc_out, 64'h200);

    step(0, 0, 0, 1, 0, 64'd5);
    step(1, 1, 0, 0, 0, 0);
    chk("rst_redir_pc", pc_out, 0);
    chk("rst_redir_v", 64'(instr_valid), 0);

    idle(); idle(); idle();
    chk("pre_zero_pc", pc_out, 64'h8);
    step(0, 0, 1, 0, 0, -64'sd2);
`ifdef FETCH_HALT_DETECT_EN
    chk("halt_valid", 64'(instr_valid), 0);
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("halt_hold", 64'(instr_valid), 0);
    end
    step(1, 0, 0, 0, 0, 0);
    idle();
    chk("halt_restart", pc_out, 64'h0);
`else
    chk("zero_pc", pc_out, 64'hC);
    chk("zero_valid", 64'(instr_valid), 1);
`endif

    for (int i = 0; i < 500; i++) begin
      r = ($urandom % 50) == 0;
      s = ($urandom % 5) == 0;
      b = ($urandom % 4) == 0;
      u = ($urandom % 8) == 0;
      z = 1'($urandom % 2);
      off = 64'(longint'(
        int'($urandom_range(0, 40)) - 20));
      step(r, s, b, u, z, off);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
